vga_pattern_gen: RTL and testbench

Pixel source for the VGA path: it generates the 12-bit RGB444 `vga_data` that the VGA timing controller consumes, from the controller's `h_addr`/`v_addr`/`vga_valid`. Four test patterns are available: vertical colour bars, horizontal colour bars, a checkerboard, and scrolling bars. A debounced push-button selects the pattern. Mode changes are deferred to frame boundaries so a frame never tears.

---
 rtl/vga_pattern_pkg.sv | 36 +++
 rtl/btn_debounce.sv | 52 +++++
 rtl/vga_pattern_gen.sv | 88 ++++++++
 tb/tb_vga_pattern_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_pkg.sv
// Shared constants, mode encoding and colour palette for the VGA test-pattern source.
package vga_pattern_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int BAR_W    = 40;
  localparam int BAR_H    = 30;

  typedef enum logic [1:0] {
    VBARS  = 2'd0,
    HBARS  = 2'd1,
    CHECK  = 2'd2,
    SCROLL = 2'd3
  } mode_e;

  localparam logic [0:15][11:0] PALETTE = {
    12'hf00, 12'hff0, 12'h0f0, 12'h00f,
    12'hf0f, 12'h0ff, 12'h800, 12'h080,
    12'h008, 12'h888, 12'h808, 12'h088,
    12'h444, 12'h222, 12'h111, 12'hfff
  };

  // Bar index for an active-area coordinate; at most 15 over the active range.
  function automatic logic [3:0] bar_idx(input logic [9:0] a, input logic [9:0] w);
    logic [9:0] q;
    q = a / w;
    return q[3:0];
  endfunction

  function automatic logic [9:0] wrap_h(input logic [10:0] s);
    logic [10:0] r;
    r = (s >= 11'(H_ACTIVE)) ? s - 11'(H_ACTIVE) : s;
    return r[9:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser and stable-level debouncer with a rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic db,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0_q, sync1_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             db_prev_q;

  // The counter only runs while the synchronised level disagrees with db; any bounce back clears it.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync1_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q   <= 1'b0;
      sync1_q   <= 1'b0;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      sync0_q   <= btn;
      sync1_q   <= sync0_q;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end

  assign db    = db_q;
  assign press = db_q & ~db_prev_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: button-selected mode, committed only at frame boundaries.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SCROLL_STEP     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        vga_valid,
  input  logic        btn,
  output logic [11:0] vga_data,
  output logic [1:0]  mode,
  output logic        frame_tick
);

  logic        db_unused;
  logic        press;
  logic [9:0]  v_prev_q;
  logic        frame_tick_q, frame_tick_d;
  logic [1:0]  pend_mode_q, pend_mode_d;
  mode_e       mode_q, mode_d;
  logic [9:0]  offset_q, offset_d;
  logic [9:0]  scroll_x;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .db    (db_unused),
    .press (press)
  );

  assign frame_tick_d = (v_prev_q != '0) && (v_addr == '0);

  // A press coinciding with the tick is not committed until the following frame.
  always_comb begin
    pend_mode_d = press ? pend_mode_q + 2'd1 : pend_mode_q;
    mode_d      = mode_q;
    offset_d    = offset_q;
    if (frame_tick_q) begin
      mode_d = mode_e'(pend_mode_q);
      if (mode_q == SCROLL) begin
        offset_d = wrap_h({1'b0, offset_q} + 11'(SCROLL_STEP));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_prev_q     <= '0;
      frame_tick_q <= 1'b0;
      pend_mode_q  <= '0;
      mode_q       <= VBARS;
      offset_q     <= '0;
    end else begin
      v_prev_q     <= v_addr;
      frame_tick_q <= frame_tick_d;
      pend_mode_q  <= pend_mode_d;
      mode_q       <= mode_d;
      offset_q     <= offset_d;
    end
  end

  assign scroll_x = wrap_h({1'b0, h_addr} + {1'b0, offset_q});

  // Zero-latency pixel mux; the timing controller samples it in the same cycle.
  always_comb begin
    vga_data = 12'h000;
    if (!rst && vga_valid) begin
      case (mode_q)
        VBARS:   vga_data = PALETTE[bar_idx(h_addr, 10'(BAR_W))];
        HBARS:   vga_data = PALETTE[bar_idx(v_addr, 10'(BAR_H))];
        CHECK:   vga_data = (h_addr[5] ^ v_addr[5]) ? 12'hfff : 12'h000;
        SCROLL:  vga_data = PALETTE[bar_idx(scroll_x, 10'(BAR_W))];
        default: vga_data = 12'h000;
      endcase
    end
  end

  assign mode       = mode_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised bench for vga_pattern_gen against a behavioural pattern/mode model.
module tb_vga_pattern_gen;

  localparam int DEB  = 4;
  localparam int STEP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_addr, v_addr;
  logic        vga_valid, btn;
  logic [11:0] vga_data;
  logic [1:0]  mode;
  logic        frame_tick;

  int n_total = 0;
  int n_bad   = 0;
  int n_press = 0;

  int m_pend = 0;
  int m_mode = 0;
  int m_off  = 0;

  logic [11:0] pal [16] = '{12'hf00, 12'hff0, 12'h0f0, 12'h00f, 12'hf0f, 12'h0ff, 12'h800, 12'h080,
                            12'h008, 12'h888, 12'h808, 12'h088, 12'h444, 12'h222, 12'h111, 12'hfff};

  vga_pattern_gen #(.DEBOUNCE_CYCLES(DEB), .SCROLL_STEP(STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .h_addr     (h_addr),
    .v_addr     (v_addr),
    .vga_valid  (vga_valid),
    .btn        (btn),
    .vga_data   (vga_data),
    .mode       (mode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.press === 1'b1) n_press++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ref_px(int md, int off, int h, int v, bit valid);
    if (!valid) return 12'h000;
    case (md)
      0: return pal[h / 40];
      1: return pal[v / 30];
      2: return (((h / 32) % 2) != ((v / 32) % 2)) ? 12'hfff : 12'h000;
      default: return pal[((h + off) % 640) / 40];
    endcase
  endfunction

  task automatic px(input int h, input int v, input bit valid, input string tag);
    h_addr = 10'(h); v_addr = 10'(v); vga_valid = valid;
    #1;
    chk(tag, vga_data, ref_px(m_mode, m_off, h, v, valid));
  endtask

  // One compressed frame: random active pixels, last row 479, then the vertical wrap to 0.
  task automatic do_frame(input int n);
    for (int i = 0; i < n; i++)
      px($urandom_range(639), $urandom_range(479, 1), ($urandom_range(3) != 0), "px_rand");
    step();
    px($urandom_range(639), 479, 1'b1, "px_last");
    step();
    px(0, 0, 1'b0, "px_blank");
    step();
    chk("tick_on", frame_tick, 1);
    chk("mode_hold", mode, m_mode);
    step();
    if (m_mode == 3) m_off = (m_off + STEP) % 640;
    m_mode = m_pend;
    chk("tick_off", frame_tick, 0);
    chk("mode_commit", mode, m_mode);
    chk("offset", dut.offset_q, m_off);
  endtask

  task automatic press_btn();
    h_addr = 0; v_addr = 10'd5; vga_valid = 1'b0;
    btn = 1'b1;
    repeat (10) step();
    btn = 1'b0;
    repeat (10) step();
    m_pend = (m_pend + 1) % 4;
    chk("pend", dut.pend_mode_q, m_pend);
  endtask

  initial begin
    int p0;
    int old_pend;
    rst = 1'b1; btn = 1'b0; h_addr = 10'd40; v_addr = 0; vga_valid = 1'b1;
    repeat (3) step();
    chk("rst_mode", mode, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_data", vga_data, 12'h000);
    rst = 1'b0;
    h_addr = 0; #1; chk("rel_h0", vga_data, 12'hf00);
    h_addr = 10'd639; #1; chk("rel_h639", vga_data, 12'hfff);
    h_addr = 10'd40; #1; chk("rel_h40", vga_data, 12'hff0);
    step();
    chk("no_tick_idle", frame_tick, 0);

    // Bouncing press: 1,0,1 then steady high.
    v_addr = 10'd5; vga_valid = 1'b0;
    p0 = n_press;
    btn = 1'b1; step(); btn = 1'b0; step(); btn = 1'b1; step();
    repeat (10) step();
    btn = 1'b0;
    repeat (10) step();
    m_pend = 1;
    chk("bounce_presses", n_press - p0, 1);
    chk("bounce_pend", dut.pend_mode_q, m_pend);
    p0 = n_press;
    btn = 1'b1; repeat (3) step(); btn = 1'b0;
    repeat (10) step();
    chk("glitch_presses", n_press - p0, 0);
    chk("glitch_pend", dut.pend_mode_q, m_pend);
    chk("mode_before_frame", mode, 0);

    do_frame(6);
    px(123, 30, 1'b1, "hbar_v30");
    chk("hbar_v30_const", vga_data, 12'hff0);
    px(7, 479, 1'b1, "hbar_v479");
    chk("hbar_v479_const", vga_data, 12'hfff);
    do_frame(6);

    press_btn();
    do_frame(4);
    chk("mode_check", mode, 2);
    px(0, 1, 1'b1, "chk_0_1");
    px(32, 1, 1'b1, "chk_32_1");
    h_addr = 0; v_addr = 0; #1; chk("chk_0_0", vga_data, 12'h000);
    h_addr = 10'd32; #1; chk("chk_32_0", vga_data, 12'hfff);
    v_addr = 10'd32; #1; chk("chk_32_32", vga_data, 12'h000);
    step();
    do_frame(6);

    press_btn();
    do_frame(3);
    chk("mode_scroll", mode, 3);
    do_frame(3);
    chk("off_after1", dut.offset_q, 2);
    px(38, 10, 1'b1, "scroll_h38");
    chk("scroll_h38_const", vga_data, 12'hff0);
    while (m_off != 638) do_frame(1);
    chk("off_638", dut.offset_q, 638);
    do_frame(2);
    chk("off_wrap", dut.offset_q, 0);
    px(0, 10, 1'b1, "wrap_h0");
    chk("wrap_h0_const", vga_data, 12'hf00);

    // Press pulse aligned with the frame tick: btn rises after edge k, press and tick both high after edge k+2+DEB.
    old_pend = m_pend;
    h_addr = 0; v_addr = 10'd7; vga_valid = 1'b0;
    step();
    btn = 1'b1;
    repeat (1 + DEB) step();
    v_addr = 0;
    step();
    chk("sim_tick", frame_tick, 1);
    chk("sim_press", dut.press, 1);
    step();
    if (m_mode == 3) m_off = (m_off + STEP) % 640;
    m_mode = old_pend;
    m_pend = (m_pend + 1) % 4;
    chk("sim_mode_old", mode, m_mode);
    chk("sim_pend_new", dut.pend_mode_q, m_pend);
    repeat (5) step();
    btn = 1'b0;
    repeat (10) step();
    do_frame(5);
    chk("sim_mode_next", mode, m_pend);

    for (int md = 0; md < 4; md++) begin
      while (m_mode != md) begin
        press_btn();
        do_frame(2);
      end
      h_addr = 10'($urandom_range(639)); v_addr = 10'($urandom_range(479)); vga_valid = 1'b0;
      #1; chk("invalid_black", vga_data, 12'h000);
      step();
      do_frame(8);
    end

    // Mid-frame reset clears all state; v_addr staying 0 must not fake a frame edge.
    v_addr = 10'd100; vga_valid = 1'b1; step();
    rst = 1'b1; step(); rst = 1'b0;
    m_mode = 0; m_pend = 0; m_off = 0;
    chk("mrst_mode", mode, 0);
    chk("mrst_pend", dut.pend_mode_q, 0);
    chk("mrst_off", dut.offset_q, 0);
    v_addr = 0; step();
    chk("mrst_no_tick", frame_tick, 0);
    do_frame(6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
